// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial shifter with a one-word holding register and completed-word counter
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic [15:0]      word_cnt
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sreg, hold;
    logic [IW-1:0] idx;
    logic hold_full, accept, consume, last_bit, direct, refill;
    // a direct load can only happen with hold empty, since accept already requires in_ready
    always_comb begin
        in_ready = !hold_full;
        accept = in_valid && in_ready;
        consume = (state == SHIFT) && shift_en;
        last_bit = consume && (idx == LAST_IDX);
        direct = accept && ((state == IDLE) || last_bit);
        refill = last_bit && hold_full;
        state_nx = (direct || refill) ? SHIFT : (last_bit ? IDLE : state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg <= '0;
            idx <= '0;
            hold <= '0;
            hold_full <= 1'b0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;
            if (direct) begin
                sreg <= in_data;
                idx <= '0;
            end else if (refill) begin
                sreg <= hold;
                idx <= '0;
            end else if (consume) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                idx <= last_bit ? '0 : idx + 1'b1;
            end
            if (accept && !direct) begin
                hold <= in_data;
                hold_full <= 1'b1;
            end else if (refill) begin
                hold_full <= 1'b0;
            end
            if (last_bit) word_cnt <= word_cnt + 16'd1;
        end
    end
    assign ser_valid = (state == SHIFT);
    assign ser_bit = ser_valid && sreg[WIDTH-1];
    assign ser_first = ser_valid && (idx == '0);
    assign ser_last = ser_valid && (idx == LAST_IDX);
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: vector table, corner sequences and a queue-based reference model for bit_serializer
module tb_bit_serializer;
    logic clk = 0, rst_n = 0, in_valid = 0, shift_en = 0;
    logic [7:0] in_data = 0;
    logic in_ready, ser_bit, ser_valid, ser_first, ser_last;
    logic [15:0] word_cnt;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_first(ser_first),
        .ser_last(ser_last), .word_cnt(word_cnt)
    );

    // reference: remaining bits of the current word as a queue, plus one held word
    logic mq[$];
    logic [7:0] m_hold = 0;
    logic m_hf = 0;
    logic [15:0] m_cnt = 0;

    typedef struct {
        logic iv;
        logic [7:0] d;
        logic se;
        logic [4:0] eo;
        logic [15:0] ec;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic iv, logic [7:0] d, logic se, logic [4:0] eo, logic [15:0] ec);
        tbl.push_back('{iv, d, se, eo, ec});
    endfunction

    task automatic m_reset();
        mq.delete();
        m_hold = 0;
        m_hf = 0;
        m_cnt = 0;
    endtask

    task automatic m_load(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
    endtask

    task automatic m_step(input logic iv, input logic [7:0] d, input logic se);
        logic acc;
        acc = iv && !m_hf;
        if (mq.size() > 0 && se) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_cnt = m_cnt + 16'd1;
        end
        if (mq.size() == 0 && m_hf) begin
            m_load(m_hold);
            m_hf = 0;
        end else if (acc) begin
            if (mq.size() == 0) m_load(d);
            else begin
                m_hold = d;
                m_hf = 1;
            end
        end
    endtask

    function automatic logic [20:0] dut_o();
        return {in_ready, ser_valid, ser_bit, ser_first, ser_last, word_cnt};
    endfunction

    function automatic logic [20:0] mdl_o();
        int n;
        n = mq.size();
        return {!m_hf, n > 0, (n > 0) ? mq[0] : 1'b0, n == 8, n == 1, m_cnt};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [7:0] d, input logic se);
        in_valid = iv;
        in_data = d;
        shift_en = se;
        @(posedge clk);
        m_step(iv, d, se);
        #1;
    endtask

    task automatic run_word(input logic [7:0] d, output int rem, output int nv);
        rem = 0;
        nv = 0;
        cyc(1, d, 1);
        check("word_load", dut_o(), mdl_o());
        for (int k = 0; k < 12 && ser_valid; k++) begin
            nv++;
            rem = ser_first ? int'(ser_bit) : (rem * 2 + int'(ser_bit)) % 5;
            cyc(0, 0, 1);
            check("word_cyc", dut_o(), mdl_o());
        end
    endtask

    initial begin
        logic [15:0] bits;
        int nv, rem;
        repeat (3) @(posedge clk);
        #1 check("reset_state", dut_o(), 21'h100000);
        m_reset();
        @(negedge clk);
        rst_n = 1;

        // single word 0x05, then 0xF0 with a 3-cycle stall at idx 3
        add(1, 8'h05, 1, 5'b11010, 0);
        add(0, 0, 1, 5'b11000, 0);
        add(0, 0, 1, 5'b11000, 0);
        add(0, 0, 1, 5'b11000, 0);
        add(0, 0, 1, 5'b11000, 0);
        add(0, 0, 1, 5'b11100, 0);
        add(0, 0, 1, 5'b11000, 0);
        add(0, 0, 1, 5'b11101, 0);
        add(0, 0, 1, 5'b10000, 1);
        add(1, 8'hF0, 1, 5'b11110, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 5'b11100, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 5'b11100, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 5'b11000, 1);
        add(0, 0, 1, 5'b11001, 1);
        add(0, 0, 1, 5'b10000, 2);
        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].d, tbl[i].se);
            check($sformatf("vec%0d", i), dut_o(), {tbl[i].eo, tbl[i].ec});
        end

        // back-to-back words through the holding register
        bits = 0;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(i < 2, (i == 0) ? 8'hA5 : 8'h3C, 1);
            check("b2b_model", dut_o(), mdl_o());
            if (i >= 1 && i <= 7) check("b2b_ready_low", in_ready, 0);
            if (ser_valid) begin
                bits = {bits[14:0], ser_bit};
                nv++;
            end
        end
        check("b2b_bits", bits, 16'hA53C);
        check("b2b_nvalid", nv, 16);
        cyc(0, 0, 1);
        check("b2b_idle", dut_o(), mdl_o());
        check("b2b_cnt", word_cnt, 4);

        // asynchronous reset at idx 4 with the holding register full
        cyc(1, 8'h81, 1);
        cyc(1, 8'h42, 1);
        repeat (3) begin
            cyc(0, 0, 1);
            check("pre_rst", dut_o(), mdl_o());
        end
        check("pre_rst_state", {ser_valid, in_ready}, 2'b10);
        #2 rst_n = 0;
        #1 check("rst_async", dut_o(), 21'h100000);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (5) begin
            cyc(0, 0, 1);
            check("post_rst", dut_o(), mdl_o());
        end

        // divide-by-5 downstream checker fed from the serial stream
        run_word(8'h0A, rem, nv);
        check("div5_0a_high", rem == 0, 1);
        check("div5_0a_bits", nv, 8);
        run_word(8'h07, rem, nv);
        check("div5_07_low", rem == 0, 0);

        // counter wrap
        force dut.word_cnt = 16'hFFFE;
        #1 release dut.word_cnt;
        m_cnt = 16'hFFFE;
        run_word(8'h11, rem, nv);
        check("cnt_ffff", word_cnt, 16'hFFFF);
        run_word(8'h22, rem, nv);
        check("cnt_wrap", word_cnt, 16'h0000);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
            check("rand", dut_o(), mdl_o());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
